// File: rtl/uart_rx_os.sv
// 8N1 oversampling UART receiver: 2-flop synchronised rxd, mid-bit sampling, byte held in a valid/ack register.
// Latency rxd fall -> rx_valid is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (+1); no backpressure, an unread byte is overwritten and flagged.
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rxd_m;
    logic             rxd_s;
    logic             rxd_q;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             fall;
    logic             half_tick;
    logic             full_tick;
    logic             cnt_clr;
    logic             sample_bit;
    logic             deliver;
    logic             stop_bad;

    // Sync flops reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_q <= rxd_s;
        end
    end

    assign fall      = rxd_q & ~rxd_s;
    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_tick) begin
                    state_nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
            end
            START: begin
                busy    = 1'b1;
                cnt_clr = half_tick;
            end
            DATA: begin
                busy       = 1'b1;
                cnt_clr    = full_tick;
                sample_bit = full_tick;
            end
            STOP: begin
                busy     = 1'b1;
                cnt_clr  = full_tick;
                deliver  = full_tick & rxd_s;
                stop_bad = full_tick & ~rxd_s;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Counter restarts on every sample, so START aligns all later samples to mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_bit) begin
                shift_reg <= {rxd_s, shift_reg[7:1]};
            end
        end
    end

    // A new byte always wins over a same-cycle ack; overrun only when the old byte was never taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver & rx_valid & ~rx_ack;
            if (deliver) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: table of frames at 16 clk/bit scored through an expected-byte queue,
// plus hand sequences for overrun, ack-on-delivery, mid-frame reset and a 4 clk/bit instance.
`timescale 1ns/1ps
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       rxd4;
    logic       rx_ack4;
    logic [7:0] rx_data4;
    logic       rx_valid4;
    logic       frame_err4;
    logic       overrun4;
    logic       busy4;

    always #5 clk = ~clk;

    uart_rx_os #(.CLKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    uart_rx_os #(.CLKS_PER_BIT(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd4),
        .rx_data   (rx_data4),
        .rx_valid  (rx_valid4),
        .rx_ack    (rx_ack4),
        .frame_err (frame_err4),
        .overrun   (overrun4),
        .busy      (busy4)
    );

    typedef struct {
        logic       glitch;
        logic [7:0] data;
        logic       stop;
        int         bit_ns;
        logic       exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs [8];
    int         checks = 0;
    int         errors = 0;
    int         ferr_cycles = 0;
    int         ov_cycles = 0;
    int         ferr4_cycles = 0;
    int         ov4_cycles = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;
    logic       lat_arm = 1'b0;
    logic       found4 = 1'b0;
    longint     t_fall = 0;
    longint     t_fall4 = 0;
    longint     lat = 0;
    longint     lat4 = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rx_valid4"}, rx_valid4, 0);
        chk({tag, "_busy4"}, busy4, 0);
    endtask

    task automatic send16(input logic [7:0] b, input logic stop, input int bit_ns);
        t_fall = $time;
        rxd = 1'b0;
        #(bit_ns);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            #(bit_ns);
        end
        rxd = stop;
        #(bit_ns);
        rxd = 1'b1;
    endtask

    task automatic send4(input logic [7:0] b);
        t_fall4 = $time;
        rxd4 = 1'b0;
        #40;
        for (int k = 0; k < 8; k++) begin
            rxd4 = b[k];
            #40;
        end
        rxd4 = 1'b1;
        #40;
    endtask

    task automatic ack16();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every new byte (valid rising, or an overwrite flagged by overrun) pops one expectation.
    always @(negedge clk) begin
        if (frame_err) ferr_cycles++;
        if (overrun) ov_cycles++;
        if (frame_err4) ferr4_cycles++;
        if (overrun4) ov4_cycles++;
        if (!rst && ((rx_valid && !prev_valid) || overrun)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got 0x%02h expected no byte", rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                chk("scoreboard_data", rx_data, exp_b);
            end
            if (lat_arm && rx_valid && !prev_valid) begin
                lat = $time - 5 - t_fall;
                lat_arm = 1'b0;
                checks++;
                if (lat < 1540 || lat > 1550) begin
                    errors++;
                    $display("FAIL latency: got %0d ns expected 1540..1550 ns", lat);
                end
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        rst     = 1'b1;
        rxd     = 1'b1;
        rxd4    = 1'b1;
        rx_ack  = 1'b0;
        rx_ack4 = 1'b0;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 160, 1'b1, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 160, 1'b1, 0};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 160, 1'b1, 0};
        vecs[3] = '{1'b0, 8'h55, 1'b1, 160, 1'b1, 0};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 160, 1'b0, 0};
        vecs[5] = '{1'b0, 8'h3C, 1'b0, 160, 1'b0, 1};
        vecs[6] = '{1'b0, 8'h5A, 1'b1, 155, 1'b1, 0};
        vecs[7] = '{1'b0, 8'hC3, 1'b1, 165, 1'b1, 0};

        repeat (3) @(posedge clk);
        #3;
        check_reset("por");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            ferr_cycles = 0;
            ov_cycles   = 0;
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
            if (i == 0) lat_arm = 1'b1;
            @(posedge clk);
            #1;
            if (vecs[i].glitch) begin
                rxd = 1'b0;
                #40;
                rxd = 1'b1;
            end else begin
                send16(vecs[i].data, vecs[i].stop, vecs[i].bit_ns);
            end
            repeat (20) @(negedge clk);
            if (vecs[i].exp_valid) last_data = vecs[i].data;
            chk($sformatf("v%0d_rx_valid", i), rx_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_frame_err_cycles", i), ferr_cycles, vecs[i].exp_ferr);
            chk($sformatf("v%0d_overrun_cycles", i), ov_cycles, 0);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_rx_data", i), rx_data, last_data);
            if (vecs[i].exp_valid) begin
                ack16();
                chk($sformatf("v%0d_ack_clears", i), rx_valid, 0);
            end
        end
        chk("latency_measured", lat_arm, 0);

        // Two bytes with no ack: the second overwrites and flags overrun.
        ferr_cycles = 0;
        ov_cycles   = 0;
        exp_q.push_back(8'h11);
        @(posedge clk);
        #1 send16(8'h11, 1'b1, 160);
        repeat (20) @(negedge clk);
        chk("ovr_first_valid", rx_valid, 1);
        chk("ovr_first_none", ov_cycles, 0);
        exp_q.push_back(8'h22);
        @(posedge clk);
        #1 send16(8'h22, 1'b1, 160);
        repeat (20) @(negedge clk);
        chk("ovr_pulse_cycles", ov_cycles, 1);
        chk("ovr_rx_data", rx_data, 8'h22);
        chk("ovr_rx_valid", rx_valid, 1);
        chk("ovr_frame_err", ferr_cycles, 0);

        // Ack lands exactly on the delivery edge (edge 155 after the line falls).
        ov_cycles = 0;
        @(posedge clk);
        #1;
        fork
            send16(8'h33, 1'b1, 160);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("ackdel_overrun", ov_cycles, 0);
        chk("ackdel_rx_valid", rx_valid, 1);
        chk("ackdel_rx_data", rx_data, 8'h33);

        // Reset in the middle of the data bits; the line finishes the frame while reset is held.
        ferr_cycles = 0;
        ov_cycles   = 0;
        @(posedge clk);
        #1;
        fork
            send16(8'h77, 1'b1, 160);
            begin
                repeat (60) @(posedge clk);
                #3;
                chk("mid_busy_before_rst", busy, 1);
                rst = 1'b1;
                #1;
                check_reset("mid");
            end
        join
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_rx_valid", rx_valid, 0);
        chk("post_rst_busy", busy, 0);
        exp_q.push_back(8'h12);
        @(posedge clk);
        #1 send16(8'h12, 1'b1, 160);
        repeat (20) @(negedge clk);
        chk("post_rst_byte_valid", rx_valid, 1);
        chk("post_rst_byte_data", rx_data, 8'h12);
        chk("post_rst_frame_err", ferr_cycles, 0);
        chk("post_rst_overrun", ov_cycles, 0);
        ack16();
        chk("post_rst_ack", rx_valid, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Same A5 frame through the 4 clk/bit instance.
        ferr4_cycles = 0;
        ov4_cycles   = 0;
        @(posedge clk);
        #1;
        fork
            send4(8'hA5);
            begin
                found4 = 1'b0;
                for (int i = 0; i < 100 && !found4; i++) begin
                    @(negedge clk);
                    if (rx_valid4) begin
                        found4 = 1'b1;
                        lat4 = $time - 5 - t_fall4;
                    end
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("c4_valid_seen", found4, 1);
        checks++;
        if (lat4 < 400 || lat4 > 410) begin
            errors++;
            $display("FAIL c4_latency: got %0d ns expected 400..410 ns", lat4);
        end
        chk("c4_rx_data", rx_data4, 8'hA5);
        chk("c4_frame_err", ferr4_cycles, 0);
        chk("c4_overrun", ov4_cycles, 0);
        chk("c4_busy", busy4, 0);
        @(posedge clk);
        #1 rx_ack4 = 1'b1;
        @(posedge clk);
        #1 rx_ack4 = 1'b0;
        @(negedge clk);
        chk("c4_ack_clears", rx_valid4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
